// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder
package mem_pkg;
   localparam int MEM_ADDR_W      = 32;
   localparam int MEM_DATA_W      = 32;
   localparam int MEM_TIMEOUT_CYC = 255;
   typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} memstate_t;
   typedef logic [MEM_DATA_W-1:0] word_t;
   typedef logic [MEM_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority grant that alternates to fetch after a data grant under contention
module mem_arbiter (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_dreq,
   input  logic i_ireq,
   input  logic i_take,
   output logic o_gnt_d,
   output logic o_gnt_i
);
   logic r_last_d;
   // data wins unless the previous grant was data and a fetch is waiting
   always_comb begin
      o_gnt_d = i_dreq & (~i_ireq | ~r_last_d);
      o_gnt_i = i_ireq & ~o_gnt_d;
   end
   // remember who was granted last so contention alternates
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_last_d <= 1'b0;
      else if (i_take) r_last_d <= o_gnt_d;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch/data requests onto a single-ported RAM; MEM_TIMEOUT_EN adds an access timeout
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ramready,
   output logic              ramerr
);
   memstate_t         r_state;
   logic              w_gnt_d, w_gnt_i, w_take, w_tmo, w_done;
   logic [DATA_W-1:0] w_load;

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
      $error("TIMEOUT_CYC must fit the 8-bit access counter");
   end

   assign w_take = (r_state == IDLE) & (dREN | dWEN | iREN);

   mem_arbiter u_arb (
      .i_clk   (CLK),
      .i_rst_n (nRST),
      .i_dreq  (dREN | dWEN),
      .i_ireq  (iREN),
      .i_take  (w_take),
      .o_gnt_d (w_gnt_d),
      .o_gnt_i (w_gnt_i)
   );

`ifdef MEM_TIMEOUT_EN
   logic       r_err;
   logic [7:0] r_cnt;
   logic       w_acc;
   assign w_acc  = (r_state == DACC) | (r_state == IACC);
   assign w_tmo  = w_acc & ~ramready & (r_cnt + 8'd1 == 8'(TIMEOUT_CYC));
   assign w_load = ramready ? ramload : '0;
   assign ramerr = r_err;
   // count access cycles (zero on every entry) and latch a sticky error on expiry
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_acc ? r_cnt + 8'd1 : 8'd0;
         r_err <= r_err | w_tmo;
      end
`else
   assign w_tmo  = 1'b0;
   assign w_load = ramload;
   assign ramerr = 1'b0;
`endif

   assign w_done = ramready | w_tmo;

   // transaction FSM: latch request on IDLE exit, drive RAM until done, pulse hit in RESP
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         r_state  <= IDLE;
         ihit     <= 1'b0;
         dhit     <= 1'b0;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         iload    <= '0;
         dload    <= '0;
      end else begin
         ihit <= 1'b0;
         dhit <= 1'b0;
         unique case (r_state)
            IDLE:
               if (w_gnt_d) begin
                  r_state  <= DACC;
                  ramREN   <= dREN & ~dWEN;
                  ramWEN   <= dWEN;
                  ramaddr  <= daddr;
                  ramstore <= dstore;
               end else if (w_gnt_i) begin
                  r_state <= IACC;
                  ramREN  <= 1'b1;
                  ramWEN  <= 1'b0;
                  ramaddr <= iaddr;
               end
            DACC:
               if (w_done) begin
                  if (ramREN) dload <= w_load;
                  dhit    <= 1'b1;
                  ramREN  <= 1'b0;
                  ramWEN  <= 1'b0;
                  r_state <= RESP;
               end
            IACC:
               if (w_done) begin
                  iload   <= w_load;
                  ihit    <= 1'b1;
                  ramREN  <= 1'b0;
                  r_state <= RESP;
               end
            RESP: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
   import mem_pkg::*;

   logic  CLK = 1'b0, nRST = 1'b0;
   logic  iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   addr_t iaddr = '0, daddr = '0, ramaddr;
   word_t dstore = '0, iload, dload, ramstore, ramload;
   logic  ihit, dhit, ramREN, ramWEN, ramready, ramerr;
   logic  ram_auto = 1'b0, man_ready = 1'b0;
   word_t man_load = '0;
   int    n_chk = 0, n_err = 0;
   logic [5:0] hits;

   mem_responder #(.TIMEOUT_CYC(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .ramerr(ramerr)
   );

   always #5 CLK = ~CLK;

   // RAM model: auto mode answers in the strobe cycle with word = addr ^ A5A50000
   assign ramready = ram_auto ? (ramREN | ramWEN) : man_ready;
   assign ramload  = ram_auto ? (32'hA5A5_0000 ^ ramaddr) : man_load;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // hits must never coincide
   always @(negedge CLK) chk("hit_excl", 32'(ihit & dhit), 32'd0);

   initial begin
      #23 nRST = 1'b1;
      #1;
      chk("rst_ihit", 32'(ihit), 0);
      chk("rst_dhit", 32'(dhit), 0);
      chk("rst_strb", {30'd0, ramREN, ramWEN}, 0);
      chk("rst_err", 32'(ramerr), 0);
      chk("rst_loads", iload | dload | ramaddr | ramstore, 0);
      tick;
      // load with 2-cycle RAM
      dREN = 1; daddr = 32'h40;
      tick;
      chk("ld_ren", 32'(ramREN), 1);
      chk("ld_addr", ramaddr, 32'h40);
      chk("ld_wen", 32'(ramWEN), 0);
      tick;
      chk("ld_wait", 32'(dhit), 0);
      man_ready = 1; man_load = 32'hDEAD_BEEF;
      tick;
      chk("ld_hit", 32'(dhit), 1);
      chk("ld_data", dload, 32'hDEAD_BEEF);
      chk("ld_ren_off", 32'(ramREN), 0);
      dREN = 0; man_ready = 0;
      tick;
      chk("ld_hit_pulse", 32'(dhit), 0);
      // store with read also raised: write wins
      dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234_5678;
      tick;
      chk("st_wen", 32'(ramWEN), 1);
      chk("st_ren", 32'(ramREN), 0);
      chk("st_data", ramstore, 32'h1234_5678);
      chk("st_addr", ramaddr, 32'h80);
      tick;
      chk("st_hold", 32'(ramWEN), 1);
      man_ready = 1; man_load = 32'hBAD0_BAD0;
      tick;
      chk("st_hit", 32'(dhit), 1);
      chk("st_dload", dload, 32'hDEAD_BEEF);
      chk("st_wen_off", 32'(ramWEN), 0);
      dREN = 0; dWEN = 0; man_ready = 0;
      tick;
`ifdef MEM_TIMEOUT_EN
      // RAM never answers: expire after 8 access cycles
      dREN = 1; daddr = 32'h20;
      for (int i = 0; i < 9; i++) begin
         tick;
         if (i == 7) chk("to_early", 32'(dhit), 0);
      end
      chk("to_hit", 32'(dhit), 1);
      chk("to_dload", dload, 0);
      chk("to_err", 32'(ramerr), 1);
      dREN = 0;
      tick;
      tick;
      chk("to_sticky", 32'(ramerr), 1);
`endif
      // reset in the middle of a data access
      dREN = 1; daddr = 32'h60;
      tick;
      chk("rm_ren", 32'(ramREN), 1);
      #2 nRST = 0;
      #1;
      chk("rm_async", {30'd0, ramREN, ramWEN}, 0);
      dREN = 0;
      tick;
      #3 nRST = 1;
      man_ready = 1;
      tick;
      chk("rm_nohit", 32'(dhit), 0);
      chk("rm_idle", 32'(ramREN), 0);
      chk("rm_dload", dload, 0);
      chk("rm_err", 32'(ramerr), 0);
      man_ready = 0;
      // contention: data first, then fetch, both held
      ram_auto = 1;
      iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h44;
      tick;
      chk("ct_daddr", ramaddr, 32'h44);
      tick;
      chk("ct_dhit", 32'(dhit), 1);
      chk("ct_dload", dload, 32'hA5A5_0044);
      tick;
      tick;
      chk("ct_iaddr", ramaddr, 32'h100);
      tick;
      chk("ct_ihit", 32'(ihit), 1);
      chk("ct_iload", iload, 32'hA5A5_0100);
      iREN = 0; dREN = 0;
      tick;
      // back-to-back fetch: a hit every 3 cycles
      iREN = 1; iaddr = 32'h0;
      for (int i = 0; i < 6; i++) begin
         tick;
         hits[i] = ihit;
         if (i == 1) begin
            chk("bb_iload0", iload, 32'hA5A5_0000);
            iaddr = 32'h4;
         end
         if (i == 4) chk("bb_iload1", iload, 32'hA5A5_0004);
      end
      chk("bb_pattern", 32'(hits), 32'b010010);
      iREN = 0;
      tick;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder serving the datapath's instruction-fetch and data-access requests; it generates ihit/dhit.
- Sits between the request/fetch logic and a single-ported RAM with variable latency.
- Arbitrates iREN vs. dREN/dWEN, issues one RAM transaction at a time, and returns load data with a single-cycle hit pulse.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- TIMEOUT_CYC, 255, RAM cycles before an access is declared failed (used only with optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction fetch request (level, held until ihit).
- iaddr  input  ADDR_W  fetch address.
- ihit  output  1  one-cycle pulse: iload valid, fetch complete.
- iload  output  DATA_W  fetched instruction, registered.
- dREN  input  1  data read request (level, registered by requester, cleared after dhit).
- dWEN  input  1  data write request (same rules as dREN).
- daddr  input  ADDR_W  data address.
- dstore  input  DATA_W  store data.
- dhit  output  1  one-cycle pulse: data access complete.
- dload  output  DATA_W  load data, registered.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- ramload  input  DATA_W  RAM read data, valid when ramready=1.
- ramready  input  1  RAM access complete this cycle.
- ramerr  output  1  sticky timeout flag (0 unless MEM_TIMEOUT_EN).

Behaviour:
- Reset (async): state=IDLE; ihit, dhit, ramREN, ramWEN, ramerr = 0; iload, dload, ramaddr, ramstore = 0.
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE arbitration:
  - dREN|dWEN -> DACC; data has priority over fetch.
  - else iREN -> IACC.
  - else stay.
  - Address, store data and op are latched on IDLE exit and held for the whole transaction.
- DACC: ramREN=latched dREN, ramWEN=latched dWEN, ramaddr=latched daddr, ramstore=latched dstore.
  - On ramready: dload<=ramload (read only; unchanged for write), dhit<=1, -> RESP.
- IACC: ramREN=1, ramaddr=latched iaddr.
  - On ramready: iload<=ramload, ihit<=1, -> RESP.
- RESP: hit pulse is high exactly this one cycle; RAM strobes low; -> IDLE.
  - Next arbitration occurs in IDLE, one cycle after the hit.
  - The requester's registered enables have cleared by then, so no duplicate service.
- Latency: request seen in IDLE at cycle t -> strobes at t+1 -> hit one cycle after ramready (minimum 3 cycles for a 1-cycle RAM).
- dREN and dWEN both high: treated as write; read ignored.
- Request deasserted mid-transaction: the transaction still completes and the hit still pulses (no abort).
- Never ihit and dhit in the same cycle.
- Starvation bound: after a dhit, if iREN is pending, the next grant goes to fetch even if data is also pending (alternate on contention).
- ramready outside DACC/IACC: ignored.
- Reset mid-transaction: abandon immediately; strobes drop asynchronously; no hit.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter increments each cycle in DACC/IACC and clears on state entry.
  - When it reaches TIMEOUT_CYC without ramready: ramerr<=1 (sticky until reset), complete the access with the matching hit pulse and load data 0, -> RESP.
- Undefined:
  - No counter; the access waits indefinitely.
  - ramerr tied to 0.

Decomposition:
- Shared package mem_pkg holds:
  - state enum memstate_t {IDLE, DACC, IACC, RESP};
  - word_t (DATA_W);
  - addr_t;
  - TIMEOUT_CYC default.
- One natural sub-module: mem_arbiter (combinational grant plus last-grant flop implementing data-priority with alternation).
- FSM and datapath stay in mem_responder.

Test Plan:
- Load: dREN=1, daddr=0x40, RAM returns 0xDEADBEEF after 2 cycles -> ramREN=1 with ramaddr=0x40, then dhit one cycle with dload=0xDEADBEEF, then ramREN=0.
- Store: dWEN=1, daddr=0x80, dstore=0x12345678 -> ramWEN=1, ramstore=0x12345678 until ramready; dhit pulse; dload unchanged.
- Contention: iREN=1 and dREN=1 simultaneously, both held -> data served first (dhit), then fetch (ihit); never both high in the same cycle.
- Back-to-back fetch: iREN held, iaddr 0x0 then 0x4, 1-cycle RAM -> ihit every 3 cycles, iload matches RAM words in order.
- Reset mid-access: assert nRST=0 while in DACC -> ramREN/ramWEN=0 immediately, no dhit, IDLE after release.
- MEM_TIMEOUT_EN, ramready stuck 0, TIMEOUT_CYC=8 -> dhit after 8 access cycles, dload=0, ramerr=1 and stays 1.
